// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
//   - PC_SRC_* : next-PC selector encodings, identical to the branch controller output
//   - state_t  : sequencer FSM states
//   - TRAP_CAUSE_* : cause codes reported on trap_cause
package pc_sequencer_pkg;

    localparam logic [1:0] PC_SRC_SEQ     = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH  = 2'b01;
    localparam logic [1:0] PC_SRC_JALR    = 2'b10;
    localparam logic [1:0] PC_SRC_ILLEGAL = 2'b11;

    localparam logic [1:0] TRAP_CAUSE_NONE     = 2'b00;
    localparam logic [1:0] TRAP_CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_CAUSE_ILLEGAL  = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC selection and target checking.
// Ports:
//   pc          in   current PC
//   pc_src      in   selector from the branch controller
//   imm         in   sign-extended branch/JAL offset
//   jalr_target in   JALR target from the ALU (bit 0 is cleared here)
//   next_pc     out  candidate next PC (modulo 2^XLEN)
//   misaligned  out  candidate is not 4-byte aligned (only for legal selectors)
//   illegal     out  selector is the reserved encoding
module pc_next_calc
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned,
    output logic            illegal
);

    always_comb begin
        next_pc = pc + XLEN'(4);
        illegal = 1'b0;
        unique case (pc_src)
            PC_SRC_SEQ:    next_pc = pc + XLEN'(4);
            PC_SRC_BRANCH: next_pc = pc + imm;
            // JALR drops bit 0 of the computed target; masking keeps every
            // input bit referenced.
            PC_SRC_JALR:   next_pc = jalr_target & ~XLEN'(1);
            default: begin
                next_pc = pc;
                illegal = 1'b1;
            end
        endcase
        misaligned = !illegal && (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer.
// Fetches one instruction, presents it for one execute slot, then commits the
// next PC chosen by the branch controller. Misaligned targets and the reserved
// selector raise a sticky trap; halt parks the sequencer until reset.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   pc_src, imm, jalr_target next-PC controls, sampled in EXEC when not stalled
//   halt, stall              execute-slot controls (stall has priority)
//   imem_rdata, imem_valid   instruction memory response
//   imem_req, imem_addr      instruction memory request (level, held until valid)
//   instr, instr_valid       execute-slot instruction for decode
//   pc, pc_plus4             current PC and its link value
//   trap, trap_pc, trap_cause sticky trap status
//   halted                   sticky halt status
//   instret                  retired-instruction counter (wraps)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            halt,
    input  logic            stall,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [1:0]      trap_cause,
    output logic            halted,
    output logic [31:0]     instret
);

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [31:0]     instr_reg;
    logic [XLEN-1:0] trap_pc_reg;
    logic [1:0]      trap_cause_reg;
    logic [31:0]     instret_reg;
    logic            imem_req_reg;
    logic            instr_valid_reg;
    logic            trap_reg;
    logic            halted_reg;

    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            illegal;

    pc_next_calc #(
        .XLEN(XLEN)
    ) u_next_calc (
        .pc          (pc_reg),
        .pc_src      (pc_src),
        .imm         (imm),
        .jalr_target (jalr_target),
        .next_pc     (next_pc),
        .misaligned  (misaligned),
        .illegal     (illegal)
    );

    // Single FSM block; the status outputs are registered alongside the state
    // so every output except pc_plus4 comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_FETCH;
            pc_reg          <= RESET_PC;
            instr_reg       <= '0;
            trap_pc_reg     <= '0;
            trap_cause_reg  <= TRAP_CAUSE_NONE;
            instret_reg     <= '0;
            imem_req_reg    <= 1'b1;
            instr_valid_reg <= 1'b0;
            trap_reg        <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr_reg       <= imem_rdata;
                        state_reg       <= ST_EXEC;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // stall > halt > pc_src
                    if (!stall) begin
                        if (halt) begin
                            state_reg       <= ST_HALT;
                            instret_reg     <= instret_reg + 32'd1;
                            instr_valid_reg <= 1'b0;
                            halted_reg      <= 1'b1;
                        end else if (illegal || misaligned) begin
                            state_reg       <= ST_TRAP;
                            trap_pc_reg     <= pc_reg;
                            trap_cause_reg  <= illegal ? TRAP_CAUSE_ILLEGAL
                                                       : TRAP_CAUSE_MISALIGN;
                            instr_valid_reg <= 1'b0;
                            trap_reg        <= 1'b1;
                        end else begin
                            state_reg       <= ST_FETCH;
                            pc_reg          <= next_pc;
                            instret_reg     <= instret_reg + 32'd1;
                            instr_valid_reg <= 1'b0;
                            imem_req_reg    <= 1'b1;
                        end
                    end
                end
                default: begin
                    // HALT and TRAP hold everything until reset.
                end
            endcase
        end
    end

    assign imem_req    = imem_req_reg;
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + XLEN'(4);
    assign trap        = trap_reg;
    assign trap_pc     = trap_pc_reg;
    assign trap_cause  = trap_cause_reg;
    assign halted      = halted_reg;
    assign instret     = instret_reg;

endmodule
